im_loader: RTL and testbench

- Write-side companion of the 4 KB word-addressed instruction memory (1024 x 32-bit, read by the single-cycle fetch path).
- Takes a byte stream from a host link, frames it, assembles big-endian 32-bit words and writes them sequentially into the IM write port starting at word 0.
- Holds the CPU (cpu_hold) while a load is in progress, so programs are loaded at run time rather than only through file initialisation.

---
 rtl/im_pkg.sv | 18 +
 rtl/im_loader_if.sv | 21 ++
 rtl/im_word_assembler.sv | 30 +++
 rtl/im_loader.sv | 159 +++++++++++++++
 tb/tb_im_loader.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/im_pkg.sv
// Shared definitions for the instruction-memory loader: IM geometry, frame layout, FSM states.
package im_pkg;

    localparam int IM_ADDR_W = 10;
    localparam int IM_WORDS  = 1024;
    localparam int LEN_BYTES = 2;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/im_loader_if.sv
// Host byte stream plus IM write port; master = host/IM side, slave = loader.
interface im_loader_if #(
    parameter int ADDR_W = 10
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_din;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, im_we, im_addr, im_din
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, im_we, im_addr, im_din
    );
endinterface

// File: rtl/im_word_assembler.sv
// 8-to-32 big-endian shift register with a 2-bit byte index.
// o_word_full flags that the byte on i_byte completes a word; o_word_next is that word.
module im_word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word_next,
    output logic        o_word_full
);
    logic [31:0] r_word;
    logic [1:0]  r_idx;

    assign o_word_next = {r_word[23:0], i_byte};
    assign o_word_full = (r_idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (i_clr) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (i_shift) begin
            r_word <= o_word_next;
            r_idx  <= r_idx + 2'd1;
        end
    end
endmodule

// File: rtl/im_loader.sv
// Frames a host byte stream (16-bit word count, then big-endian words) and writes the IM from word 0.
// im_we one cycle after each word's 4th byte; byte_ready drops outside LEN/DATA states.
module im_loader
    import im_pkg::*;
#(
    parameter int ADDR_W    = IM_ADDR_W,
    parameter int MAX_WORDS = IM_WORDS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    im_loader_if.slave      bus,
    output logic            cpu_hold,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [ADDR_W:0] words_loaded
);
    localparam logic [16:0]       MAX_N   = 17'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] IDX_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE = 1;

    state_t            r_state;
    state_t            w_next;
    logic              w_byte_ready;
    logic              w_im_we;
    logic              w_xfer;
    logic              w_begin;
    logic [15:0]       w_len;
    logic              w_len_ok;
    logic [ADDR_W:0]   w_words_inc;
    logic              w_last;
    logic [31:0]       w_word_next;
    logic              w_word_full;

    logic [7:0]        r_len_hi;
    logic [15:0]       r_len;
    logic [ADDR_W-1:0] r_index;
    logic [ADDR_W:0]   r_words;
    logic [ADDR_W-1:0] r_im_addr;
    logic [31:0]       r_im_din;
    logic              r_busy;
    logic              r_hold;
    logic              r_done;
    logic              r_error;

    assign w_xfer      = bus.byte_valid && w_byte_ready;
    assign w_begin     = start && (r_state == IDLE || r_state == DONE || r_state == ERR);
    assign w_len       = {r_len_hi, bus.byte_data};
    assign w_len_ok    = (w_len != 16'd0) && ({1'b0, w_len} <= MAX_N);
    assign w_words_inc = r_words + CNT_ONE;
    assign w_last      = (16'(w_words_inc) == r_len);

    im_word_assembler u_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_begin),
        .i_shift     (r_state == DATA && w_xfer),
        .i_byte      (bus.byte_data),
        .o_word_next (w_word_next),
        .o_word_full (w_word_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_byte_ready = 1'b0;
        w_im_we      = 1'b0;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (start) w_next = LEN_HI;
            end
            LEN_HI: begin
                w_byte_ready = 1'b1;
                if (w_xfer) w_next = LEN_LO;
            end
            LEN_LO: begin
                w_byte_ready = 1'b1;
                if (w_xfer) w_next = w_len_ok ? DATA : ERR;
            end
            DATA: begin
                w_byte_ready = 1'b1;
                if (w_xfer && w_word_full) w_next = WRITE;
            end
            WRITE: begin
                w_im_we = 1'b1;
                w_next  = w_last ? DONE : DATA;
            end
            default: w_next = IDLE;
        endcase
    end

    // Address/data are captured with the 4th byte so they stay put after the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len_hi  <= '0;
            r_len     <= '0;
            r_index   <= '0;
            r_words   <= '0;
            r_im_addr <= '0;
            r_im_din  <= '0;
            r_busy    <= 1'b0;
            r_hold    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else if (w_begin) begin
            r_index   <= '0;
            r_words   <= '0;
            r_busy    <= 1'b1;
            r_hold    <= 1'b1;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            case (r_state)
                LEN_HI: if (w_xfer) r_len_hi <= bus.byte_data;
                LEN_LO: begin
                    if (w_xfer) begin
                        r_len <= w_len;
                        if (!w_len_ok) begin
                            r_busy  <= 1'b0;
                            r_hold  <= 1'b0;
                            r_error <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (w_xfer && w_word_full) begin
                        r_im_addr <= r_index;
                        r_im_din  <= w_word_next;
                    end
                end
                WRITE: begin
                    r_index <= r_index + IDX_ONE;
                    r_words <= w_words_inc;
                    if (w_last) begin
                        r_busy <= 1'b0;
                        r_hold <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_ready = w_byte_ready;
    assign bus.im_we      = w_im_we;
    assign bus.im_addr    = r_im_addr;
    assign bus.im_din     = r_im_din;
    assign cpu_hold       = r_hold;
    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;
    assign words_loaded   = r_words;
endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: a frame-level model predicts every IM write and its cycle.
module tb_im_loader;
    import im_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic cpu_hold, busy, done, error;
    logic [IM_ADDR_W:0] words_loaded;

    always #5 clk = ~clk;

    im_loader_if #(.ADDR_W(IM_ADDR_W)) bus();

    im_loader #(.ADDR_W(IM_ADDR_W), .MAX_WORDS(IM_WORDS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int frame_pos = 0;

    logic [IM_ADDR_W-1:0] exp_addr[$];
    logic [31:0]          exp_data[$];
    int                   exp_cyc[$];
    logic [7:0]           tx[$];
    logic [31:0]          wl[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected writes: word k of the frame lands at address k, one cycle after its 4th byte.
    always @(negedge clk) begin
        if (rst_n && bus.im_we) begin
            if (exp_addr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%h din=%h expected no write", bus.im_addr, bus.im_din);
            end else begin
                chk("wr_addr", 32'(bus.im_addr), 32'(exp_addr.pop_front()));
                chk("wr_data", bus.im_din, exp_data.pop_front());
                chk("ready_during_write", 32'(bus.byte_ready), 32'd0);
                if (exp_cyc.size() != 0) chk("wr_latency", 32'(cyc), 32'(exp_cyc.pop_front()));
                else chk("wr_latency_known", 32'd0, 32'd1);
            end
        end
    end

    task automatic build(input logic [15:0] n, input bit model_all);
        tx.delete();
        tx.push_back(n[15:8]);
        tx.push_back(n[7:0]);
        for (int k = 0; k < wl.size(); k++) begin
            logic [31:0] w;
            w = wl[k];
            tx.push_back(w[31:24]);
            tx.push_back(w[23:16]);
            tx.push_back(w[15:8]);
            tx.push_back(w[7:0]);
            if (model_all) begin
                exp_addr.push_back(IM_ADDR_W'(k));
                exp_data.push_back(w);
            end
        end
    endtask

    task automatic begin_load();
        @(posedge clk); #1;
        start = 1'b1;
        frame_pos = 0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_hold", 32'(cpu_hold), 32'd1);
        chk("start_done", 32'(done), 32'd0);
        chk("start_error", 32'(error), 32'd0);
        chk("start_words", 32'(words_loaded), 32'd0);
        chk("start_ready", 32'(bus.byte_ready), 32'd1);
    endtask

    task automatic send(input bit gaps, input int start_at);
        int i = 0;
        int stall = 0;
        int tog = 0;
        bit v;
        bit pulsed = 1'b0;
        while (i < tx.size()) begin
            @(posedge clk); #1;
            v = gaps ? ((tog % 2) == 0) : 1'b1;
            tog++;
            bus.byte_valid = v;
            bus.byte_data  = tx[i];
            start = (i == start_at && !pulsed);
            if (start) pulsed = 1'b1;
            @(negedge clk);
            if (v && bus.byte_ready) begin
                i++;
                frame_pos++;
                stall = 0;
                if (frame_pos > LEN_BYTES && ((frame_pos - LEN_BYTES) % 4) == 0)
                    exp_cyc.push_back(cyc + 1);
            end else begin
                stall++;
            end
            if (stall > 40) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: byte %0d of %0d not accepted", i, tx.size());
                break;
            end
        end
        @(posedge clk); #1;
        bus.byte_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", budget);
        end
    endtask

    task automatic check_end(input bit e_done, input bit e_err, input int e_words);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_hold", 32'(cpu_hold), 32'd0);
        chk("end_done", 32'(done), 32'(e_done));
        chk("end_error", 32'(error), 32'(e_err));
        chk("end_words", 32'(words_loaded), 32'(e_words));
        chk("end_pending", 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
        chk({tag, "_we"}, 32'(bus.im_we), 32'd0);
        chk({tag, "_addr"}, 32'(bus.im_addr), 32'd0);
        chk({tag, "_din"}, bus.im_din, 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic refused(input string tag);
        @(posedge clk); #1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk(tag, 32'(bus.byte_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.byte_valid = 1'b0;
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        #2;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic load, continuous stream.
        wl = '{32'h20080005, 32'h01095020};
        begin_load();
        build(16'd2, 1'b1);
        send(1'b0, -1);
        wait_idle(50);
        check_end(1'b1, 1'b0, 2);
        chk("basic_addr_hold", 32'(bus.im_addr), 32'd1);
        chk("basic_din_hold", bus.im_din, 32'h01095020);

        // Same frame with valid toggling each cycle.
        begin_load();
        build(16'd2, 1'b1);
        send(1'b1, -1);
        wait_idle(50);
        check_end(1'b1, 1'b0, 2);

        // Zero and oversize lengths.
        wl.delete();
        begin_load();
        build(16'h0000, 1'b0);
        send(1'b0, -1);
        wait_idle(20);
        check_end(1'b0, 1'b1, 0);
        refused("err0_ready");
        begin_load();
        build(16'h0401, 1'b0);
        send(1'b0, -1);
        wait_idle(20);
        check_end(1'b0, 1'b1, 0);
        refused("err1025_ready");

        // Full memory: word k = k.
        wl.delete();
        for (int k = 0; k < IM_WORDS; k++) wl.push_back(32'(k));
        begin_load();
        build(16'h0400, 1'b1);
        send(1'b0, -1);
        wait_idle(10000);
        check_end(1'b1, 1'b0, 1024);
        chk("full_last_addr", 32'(bus.im_addr), 32'd1023);
        chk("full_last_din", bus.im_din, 32'h000003FF);
        repeat (10) @(negedge clk);
        chk("full_no_tail_write", 32'(exp_addr.size()), 32'd0);

        // Reset after 6 data bytes of a 3-word frame: only word 0 reaches the IM.
        wl = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
        begin_load();
        build(16'd3, 1'b0);
        exp_addr.push_back('0);
        exp_data.push_back(32'h11223344);
        tx = tx[0:7];
        send(1'b0, -1);
        #2 rst_n = 1'b0;
        #1;
        check_zero("midrst");
        chk("midrst_written", 32'(exp_addr.size()), 32'd0);
        exp_addr.delete();
        exp_data.delete();
        exp_cyc.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wl = '{32'hCAFEF00D, 32'h12345678};
        begin_load();
        build(16'd2, 1'b1);
        send(1'b0, -1);
        wait_idle(50);
        check_end(1'b1, 1'b0, 2);

        // start during DATA is ignored; start after DONE begins a new load.
        wl = '{32'h00000001, 32'h00000002, 32'h00000003};
        begin_load();
        build(16'd3, 1'b1);
        send(1'b0, 5);
        wait_idle(60);
        check_end(1'b1, 1'b0, 3);
        wl = '{32'hA0B0C0D0};
        begin_load();
        build(16'd1, 1'b1);
        send(1'b0, -1);
        wait_idle(30);
        check_end(1'b1, 1'b0, 1);
        chk("reload_din", bus.im_din, 32'hA0B0C0D0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
